// File: rtl/noc_task_streamer_pkg.sv
// Shared types and sizing helpers for the NoC task streamer.
package noc_task_streamer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    SIZE    = 2'd2,
    PAYLOAD = 2'd3
  } state_t;

  // Flits needed to carry one 32-bit payload word.
  function automatic int calc_fpw(input int flit_size);
    return 32 / flit_size;
  endfunction

  // Longest request whose flit count still fits in a single flit.
  function automatic logic [15:0] max_words(input int flit_size);
    return (flit_size == 16) ? 16'h7FFF : 16'hFFFF;
  endfunction

endpackage

// File: rtl/noc_task_streamer_fifo.sv
// Synchronous single-clock FIFO with a registered occupancy count.
module sync_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [DATA_W-1:0] head_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $fatal(1, "sync_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       count_q;
  logic              do_push, do_pop;

  assign full_o  = (count_q == (AW + 1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  // NOTE: the storage array is deliberately not reset; pointers and count alone
  // define which entries are valid, so the array can map onto plain RAM cells.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
    end
  end

endmodule

// File: rtl/noc_task_streamer.sv
// Frames packet requests plus a 32-bit word stream into credit-based NoC flits
// (target, flit count, payload) for a router local port.
module noc_task_streamer
  import noc_task_streamer_pkg::*;
#(
  parameter int FLIT_SIZE = 32,
  parameter int BUF_DEPTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [15:0]          req_target_i,
  input  logic [15:0]          req_words_i,
  input  logic                 word_valid_i,
  output logic                 word_ready_o,
  input  logic [31:0]          word_i,
  output logic                 tx_o,
  input  logic                 credit_i,
  output logic [FLIT_SIZE-1:0] data_o,
  output logic                 busy_o,
  output logic                 pkt_done_o,
  output logic                 err_o
);

  localparam int FPW = calc_fpw(FLIT_SIZE);

  state_t               state_q, state_d;
  logic [FLIT_SIZE-1:0] target_q, count_q;
  logic [FLIT_SIZE-1:0] target_ext, count_ext, payload_flit;
  logic [15:0]          words_q;
  logic                 half_q, done_q, err_q, done_d;
  logic                 fifo_full, fifo_empty, fifo_pop;
  logic [31:0]          fifo_head;
  logic                 req_fire, req_illegal, payload_xfer, last_half;

  if (FLIT_SIZE == 32) begin : g_flit32
    assign target_ext   = {16'h0000, req_target_i};
    assign count_ext    = {16'h0000, req_words_i};
    assign payload_flit = fifo_head;
  end else if (FLIT_SIZE == 16) begin : g_flit16
    assign target_ext   = req_target_i;
    assign count_ext    = {req_words_i[14:0], 1'b0};
    assign payload_flit = half_q ? fifo_head[15:0] : fifo_head[31:16];
  end else begin : g_bad_flit
    $fatal(1, "noc_task_streamer: FLIT_SIZE must be 16 or 32");
  end

  assign req_ready_o  = rst_ni && (state_q == IDLE);
  assign req_fire     = req_valid_i && req_ready_o;
  assign req_illegal  = (req_words_i > max_words(FLIT_SIZE));
  assign last_half    = (FPW == 1) || half_q;
  assign payload_xfer = (state_q == PAYLOAD) && !fifo_empty && credit_i;
  assign fifo_pop     = payload_xfer && last_half;
  assign word_ready_o = !fifo_full;
  assign busy_o       = (state_q != IDLE);
  assign pkt_done_o   = done_q;
  assign err_o        = err_q;

  sync_fifo #(
    .DATA_W(32),
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (word_valid_i),
    .pop_i  (fifo_pop),
    .data_i (word_i),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .head_o (fifo_head)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // tx_o/data_o decode only state and registered FIFO contents, so credit_i
  // never reaches them combinationally.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path through
    // the case statement can leave a latch behind.
    state_d = state_q;
    tx_o    = 1'b0;
    data_o  = '0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_fire && !req_illegal) state_d = HEADER;
      end
      HEADER: begin
        tx_o   = 1'b1;
        data_o = target_q;
        if (credit_i) state_d = SIZE;
      end
      SIZE: begin
        tx_o   = 1'b1;
        data_o = count_q;
        if (credit_i) begin
          if (words_q == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        tx_o   = !fifo_empty;
        data_o = payload_flit;
        if (fifo_pop && words_q == 16'd1) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      target_q <= '0;
      count_q  <= '0;
      words_q  <= '0;
      half_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= done_d;
      err_q  <= req_fire && req_illegal;
      if (req_fire && !req_illegal) begin
        target_q <= target_ext;
        count_q  <= count_ext;
        words_q  <= req_words_i;
        half_q   <= 1'b0;
      end
      if (fifo_pop) words_q <= words_q - 16'd1;
      if (payload_xfer && FPW == 2) half_q <= !half_q;
    end
  end

endmodule

// File: tb/tb_noc_task_streamer.sv
// Scoreboard bench: one 32-bit-flit and one 16-bit-flit streamer driven by directed packets.
module tb_noc_task_streamer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        req_valid_a, req_ready_a, word_valid_a, word_ready_a;
  logic        tx_a, credit_a, busy_a, done_a, err_a;
  logic [15:0] target_a, words_a;
  logic [31:0] word_a, data_a;

  logic        req_valid_b, req_ready_b, word_valid_b, word_ready_b;
  logic        tx_b, credit_b, busy_b, done_b, err_b;
  logic [15:0] target_b, words_b;
  logic [31:0] word_b;
  logic [15:0] data_b;

  noc_task_streamer #(.FLIT_SIZE(32), .BUF_DEPTH(8)) u_dut32 (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid_a), .req_ready_o(req_ready_a),
    .req_target_i(target_a), .req_words_i(words_a),
    .word_valid_i(word_valid_a), .word_ready_o(word_ready_a), .word_i(word_a),
    .tx_o(tx_a), .credit_i(credit_a), .data_o(data_a),
    .busy_o(busy_a), .pkt_done_o(done_a), .err_o(err_a)
  );

  noc_task_streamer #(.FLIT_SIZE(16), .BUF_DEPTH(4)) u_dut16 (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid_b), .req_ready_o(req_ready_b),
    .req_target_i(target_b), .req_words_i(words_b),
    .word_valid_i(word_valid_b), .word_ready_o(word_ready_b), .word_i(word_b),
    .tx_o(tx_b), .credit_i(credit_b), .data_o(data_b),
    .busy_o(busy_b), .pkt_done_o(done_b), .err_o(err_b)
  );

  int checks   = 0;
  int failures = 0;
  int done_cnt_a = 0, done_cnt_b = 0, err_cnt_a = 0, err_cnt_b = 0;

  logic [31:0] exp_a [$];
  logic [15:0] exp_b [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitors: a flit transfers at the next posedge when tx && credit at the negedge.
  logic        stall_a = 1'b0, stall_b = 1'b0;
  logic [31:0] held_a;
  logic [15:0] held_b;

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_a = 1'b0;
    end else begin
      if (stall_a) begin
        check("a_stall_tx", 32'(tx_a), 32'd1);
        check("a_stall_data", data_a, held_a);
      end
      if (tx_a && credit_a) begin
        if (exp_a.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL a_extra_flit actual=%h required=none (t=%0t)", data_a, $time);
        end else begin
          check("a_flit", data_a, exp_a.pop_front());
        end
      end
      stall_a = tx_a && !credit_a;
      held_a  = data_a;
      if (done_a) done_cnt_a++;
      if (err_a)  err_cnt_a++;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_b = 1'b0;
    end else begin
      if (stall_b) begin
        check("b_stall_tx", 32'(tx_b), 32'd1);
        check("b_stall_data", 32'(data_b), 32'(held_b));
      end
      if (tx_b && credit_b) begin
        if (exp_b.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL b_extra_flit actual=%h required=none (t=%0t)", data_b, $time);
        end else begin
          check("b_flit", 32'(data_b), 32'(exp_b.pop_front()));
        end
      end
      stall_b = tx_b && !credit_b;
      held_b  = data_b;
      if (done_b) done_cnt_b++;
      if (err_b)  err_cnt_b++;
    end
  end

  task automatic push_a(input logic [31:0] w);
    check("a_word_ready", 32'(word_ready_a), 32'd1);
    word_valid_a = 1'b1;
    word_a       = w;
    tick();
    word_valid_a = 1'b0;
  endtask

  task automatic push_b(input logic [31:0] w);
    check("b_word_ready", 32'(word_ready_b), 32'd1);
    word_valid_b = 1'b1;
    word_b       = w;
    tick();
    word_valid_b = 1'b0;
  endtask

  task automatic req_a(input logic [15:0] t, input logic [15:0] n);
    check("a_req_ready", 32'(req_ready_a), 32'd1);
    req_valid_a = 1'b1;
    target_a    = t;
    words_a     = n;
    tick();
    req_valid_a = 1'b0;
  endtask

  task automatic req_b(input logic [15:0] t, input logic [15:0] n);
    check("b_req_ready", 32'(req_ready_b), 32'd1);
    req_valid_b = 1'b1;
    target_b    = t;
    words_b     = n;
    tick();
    req_valid_b = 1'b0;
  endtask

  task automatic wait_idle_a(input string name);
    int n = 0;
    while (busy_a && n < 200) begin
      tick();
      n++;
    end
    check(name, 32'(busy_a), 32'd0);
    tick();
  endtask

  task automatic wait_idle_b(input string name);
    int n = 0;
    while (busy_b && n < 200) begin
      tick();
      n++;
    end
    check(name, 32'(busy_b), 32'd0);
    tick();
  endtask

  logic [31:0] d6 [3] = '{32'hD000_0000, 32'hD111_1111, 32'hD222_2222};
  logic [7:0]  pat_b  = 8'b0110_1101;

  initial begin
    rst_n = 1'b0;
    req_valid_a = 1'b0; word_valid_a = 1'b0; credit_a = 1'b0;
    target_a = '0; words_a = '0; word_a = '0;
    req_valid_b = 1'b0; word_valid_b = 1'b0; credit_b = 1'b0;
    target_b = '0; words_b = '0; word_b = '0;
    tick();
    tick();

    // Reset state
    check("rst_tx_a", 32'(tx_a), 32'd0);
    check("rst_data_a", data_a, 32'd0);
    check("rst_req_ready_a", 32'(req_ready_a), 32'd0);
    check("rst_busy_a", 32'(busy_a), 32'd0);
    check("rst_done_a", 32'(done_a), 32'd0);
    check("rst_err_a", 32'(err_a), 32'd0);
    check("rst_word_ready_a", 32'(word_ready_a), 32'd1);
    check("rst_tx_b", 32'(tx_b), 32'd0);
    check("rst_data_b", 32'(data_b), 32'd0);
    check("rst_req_ready_b", 32'(req_ready_b), 32'd0);
    rst_n = 1'b1;
    tick();

    // 32-bit flits, three pre-loaded words, credit held high
    credit_a = 1'b1;
    push_a(32'hA000_0000);
    push_a(32'hA000_0001);
    push_a(32'hA000_0002);
    exp_a.push_back(32'h0000_0101);
    exp_a.push_back(32'h0000_0003);
    exp_a.push_back(32'hA000_0000);
    exp_a.push_back(32'hA000_0001);
    exp_a.push_back(32'hA000_0002);
    req_a(16'h0101, 16'd3);
    check("t1_header_latency_tx", 32'(tx_a), 32'd1);
    check("t1_header_latency_data", data_a, 32'h0000_0101);
    repeat (5) tick();
    check("t1_done_after_5", 32'(done_a), 32'd1);
    check("t1_idle_after_5", 32'(busy_a), 32'd0);
    tick();
    check("t1_done_one_cycle", 32'(done_a), 32'd0);
    check("t1_done_count", 32'(done_cnt_a), 32'd1);
    check("t1_queue_drained", 32'(exp_a.size()), 32'd0);

    // Credit stalls during payload
    push_a(32'hB000_0000);
    push_a(32'hB111_1111);
    exp_a.push_back(32'h0000_0005);
    exp_a.push_back(32'h0000_0002);
    exp_a.push_back(32'hB000_0000);
    exp_a.push_back(32'hB111_1111);
    req_a(16'h0005, 16'd2);
    tick();
    tick();
    credit_a = 1'b1; tick();
    credit_a = 1'b0; tick();
    tick();
    credit_a = 1'b1; tick();
    check("t3_idle", 32'(busy_a), 32'd0);
    tick();
    check("t3_done_count", 32'(done_cnt_a), 32'd2);
    check("t3_queue_drained", 32'(exp_a.size()), 32'd0);

    // Zero-length packet leaves a prefetched word for the next request
    push_a(32'hC0C0_C0C0);
    exp_a.push_back(32'h0000_0042);
    exp_a.push_back(32'h0000_0000);
    req_a(16'h0042, 16'd0);
    wait_idle_a("t4_zero_idle");
    check("t4_zero_done_count", 32'(done_cnt_a), 32'd3);
    check("t4_zero_queue", 32'(exp_a.size()), 32'd0);
    exp_a.push_back(32'h0000_0043);
    exp_a.push_back(32'h0000_0001);
    exp_a.push_back(32'hC0C0_C0C0);
    req_a(16'h0043, 16'd1);
    wait_idle_a("t4_next_idle");
    check("t4_next_done_count", 32'(done_cnt_a), 32'd4);
    check("t4_next_queue", 32'(exp_a.size()), 32'd0);

    // 16-bit flits: halves high first
    credit_b = 1'b1;
    push_b(32'hDEAD_BEEF);
    exp_b.push_back(16'h0203);
    exp_b.push_back(16'h0002);
    exp_b.push_back(16'hDEAD);
    exp_b.push_back(16'hBEEF);
    req_b(16'h0203, 16'd1);
    check("t2_header_latency", 32'(data_b), 32'h0000_0203);
    wait_idle_b("t2_idle");
    check("t2_done_count", 32'(done_cnt_b), 32'd1);
    check("t2_queue", 32'(exp_b.size()), 32'd0);

    // Overflowing length rejected, then a legal request proceeds
    req_b(16'h0300, 16'h8000);
    check("t5_err_pulse", 32'(err_b), 32'd1);
    check("t5_no_tx", 32'(tx_b), 32'd0);
    check("t5_stay_idle", 32'(busy_b), 32'd0);
    tick();
    check("t5_err_one_cycle", 32'(err_b), 32'd0);
    check("t5_still_no_tx", 32'(tx_b), 32'd0);
    check("t5_err_count", 32'(err_cnt_b), 32'd1);
    push_b(32'h1234_5678);
    exp_b.push_back(16'h0404);
    exp_b.push_back(16'h0002);
    exp_b.push_back(16'h1234);
    exp_b.push_back(16'h5678);
    req_b(16'h0404, 16'd1);
    wait_idle_b("t5_legal_idle");
    check("t5_done_count", 32'(done_cnt_b), 32'd2);

    // 16-bit flits with credit stalls landing between halves
    push_b(32'hCAFE_F00D);
    push_b(32'h0102_0304);
    exp_b.push_back(16'h0009);
    exp_b.push_back(16'h0004);
    exp_b.push_back(16'hCAFE);
    exp_b.push_back(16'hF00D);
    exp_b.push_back(16'h0102);
    exp_b.push_back(16'h0304);
    req_b(16'h0009, 16'd2);
    for (int i = 0; i < 40 && busy_b; i++) begin
      credit_b = pat_b[i % 8];
      tick();
    end
    credit_b = 1'b1;
    wait_idle_b("t3b_idle");
    check("t3b_done_count", 32'(done_cnt_b), 32'd3);
    check("t3b_queue", 32'(exp_b.size()), 32'd0);

    // Trickled words produce tx gaps; then reset mid-packet
    credit_a = 1'b1;
    exp_a.push_back(32'h0000_0077);
    exp_a.push_back(32'h0000_0003);
    exp_a.push_back(d6[0]);
    exp_a.push_back(d6[1]);
    req_a(16'h0077, 16'd3);
    tick();
    tick();
    check("t6_underrun_tx", 32'(tx_a), 32'd0);
    check("t6_underrun_busy", 32'(busy_a), 32'd1);
    for (int i = 0; i < 2; i++) begin
      push_a(d6[i]);
      check("t6_word_tx", 32'(tx_a), 32'd1);
      tick();
      check("t6_gap_tx", 32'(tx_a), 32'd0);
      tick();
    end
    credit_a = 1'b0;
    push_a(d6[2]);
    check("t6_stalled_tx", 32'(tx_a), 32'd1);
    rst_n = 1'b0;
    tick();
    check("t6_rst_tx", 32'(tx_a), 32'd0);
    check("t6_rst_busy", 32'(busy_a), 32'd0);
    check("t6_rst_req_ready", 32'(req_ready_a), 32'd0);
    check("t6_rst_word_ready", 32'(word_ready_a), 32'd1);
    check("t6_rst_queue", 32'(exp_a.size()), 32'd0);
    rst_n    = 1'b1;
    credit_a = 1'b1;
    tick();
    exp_a.push_back(32'h0000_0088);
    exp_a.push_back(32'h0000_0001);
    exp_a.push_back(32'hE000_000E);
    req_a(16'h0088, 16'd1);
    tick();
    tick();
    tick();
    check("t6_fifo_flushed_tx", 32'(tx_a), 32'd0);
    check("t6_fifo_flushed_busy", 32'(busy_a), 32'd1);
    push_a(32'hE000_000E);
    wait_idle_a("t6_after_rst_idle");
    check("t6_done_count", 32'(done_cnt_a), 32'd5);

    check("final_queue_a", 32'(exp_a.size()), 32'd0);
    check("final_queue_b", 32'(exp_b.size()), 32'd0);
    check("final_err_a", 32'(err_cnt_a), 32'd0);
    check("final_err_b", 32'(err_cnt_b), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/noc_task_streamer.md
Name: noc_task_streamer

Overview:
- Synthesizable, parametrised successor to the simulation-only task injection path.
- Takes packet requests (target PE address, payload length in 32-bit words) and a 32-bit payload word stream.
- Frames each request as one NoC packet, serialised onto a credit-based local port of width FLIT_SIZE.
- Sits between a boot/loader source (DMA, debug link, memory reader) and a router local input port; used to inject the mapper task, its descriptor and the remaining management tasks in hardware.

Parameters:
- FLIT_SIZE, 32, NoC flit width; legal values 16 or 32; any other value is an elaboration error ($fatal).
- BUF_DEPTH, 8, payload FIFO depth in 32-bit words; power of two, at least 2.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, synchronous, active-low.
- req_valid_i  in  1  packet request valid.
- req_ready_o  out  1  packet request accepted when valid&&ready.
- req_target_i  in  16  destination PE address.
- req_words_i  in  16  payload length in 32-bit words.
- word_valid_i  in  1  payload word valid.
- word_ready_o  out  1  payload FIFO can accept a word.
- word_i  in  32  payload word.
- tx_o  out  1  flit valid toward router.
- credit_i  in  1  router can take a flit; a transfer happens at a posedge where tx_o && credit_i.
- data_o  out  FLIT_SIZE  flit data.
- busy_o  out  1  high whenever state != IDLE.
- pkt_done_o  out  1  one-cycle pulse after the last flit of a packet transfers.
- err_o  out  1  one-cycle pulse when a request is rejected.

Behaviour:
- Clock and reset:
  - Single clock clk_i; reset is synchronous, active-low, on rst_ni.
  - Reset values: tx_o=0, data_o=0, req_ready_o=0 during reset, busy_o=0, pkt_done_o=0, err_o=0, FIFO empty, state IDLE.
- Flit ratio:
  - FPW (flits per word) = 32/FLIT_SIZE, so 1 or 2.
  - FLIT_SIZE=16: each word splits into high half first, then low half.
- Packet format:
  - flit0 = req_target_i, zero-extended to FLIT_SIZE.
  - flit1 = payload flit count = req_words_i*FPW, FLIT_SIZE bits.
  - Then the payload flits.
- Request checks:
  - Reject when FLIT_SIZE=16 and req_words_i >= 16'h8000, because the count would overflow.
  - On reject: request is consumed (ready high), err_o pulses next cycle, no flits are sent, state stays IDLE.
- FSM states IDLE, HEADER, SIZE, PAYLOAD:
  - IDLE: req_ready_o=1. An accepted legal request latches target, count and remaining words, and moves to HEADER.
  - HEADER: tx_o=1, data_o=target. On credit_i go to SIZE.
  - SIZE: tx_o=1, data_o=count. On credit_i go to PAYLOAD if words>0. If words==0, go to IDLE and pulse pkt_done_o.
  - PAYLOAD: tx_o=1 only when the FIFO is non-empty. data_o = FIFO head (FPW=1), or the selected half per a half-select register (FPW=2).
    - On transfer the half-select toggles; the FIFO pops after the last half.
    - When the final flit transfers: go to IDLE, pulse pkt_done_o the following cycle.
- Latency: a request accepted at edge N gives tx_o=1 with the header from cycle N+1. There is no idle bubble between HEADER, SIZE and PAYLOAD when credit_i is held high.
- No combinational path from credit_i, req_valid_i or word_valid_i to tx_o or data_o; those outputs derive only from registers and the FIFO head.
- tx_o drops only when the FIFO underruns in PAYLOAD or the packet ends. data_o holds stable while tx_o && !credit_i.
- FIFO:
  - word_ready_o = !full, independent of FSM state; payload may be prefetched before its request.
  - Simultaneous push and pop when full is not allowed (ready is low). Push and pop when empty is allowed; the word is presented the next cycle.
  - Pointers wrap modulo BUF_DEPTH with a separate count register.
- Request ownership: words beyond a packet's length stay in the FIFO and belong to the next request. The producer owns consistency.
- Reset mid-packet: next edge forces IDLE, tx_o=0, FIFO flushed, half-select cleared. A partial packet is abandoned.

Decomposition:
- Package noc_task_streamer_pkg holds:
  - state enum (IDLE, HEADER, SIZE, PAYLOAD);
  - localparam function for FPW;
  - MAX_WORDS limit function.
- Sub-module sync_fifo (DATA_W=32, DEPTH=BUF_DEPTH) with push/pop/full/empty/head, synchronous active-low reset.

Test Plan:
1. FLIT_SIZE=32, target 16'h0101, 3 words A0,A1,A2 pre-loaded, credit_i=1 -> flits 0x00000101, 0x00000003, A0, A1, A2 on 5 consecutive edges; pkt_done_o pulses once.
2. FLIT_SIZE=16, word 0xDEADBEEF, target 0x0203 -> flits 0x0203, 0x0002, 0xDEAD, 0xBEEF.
3. credit_i toggling 1,0,0,1 during PAYLOAD -> data_o stable while stalled; no flit duplicated or skipped.
4. words=0 -> exactly two flits (target, 0); pkt_done_o pulses; FIFO untouched.
5. FLIT_SIZE=16, req_words_i=0x8000 -> err_o pulse; tx_o stays 0; next legal request proceeds normally.
6. Request first, words trickled every 3rd cycle -> tx_o gaps in PAYLOAD. Then rst_ni=0 mid-packet -> tx_o=0 next edge, FIFO empty, busy_o=0.
